booth_mac_ctrl: RTL and testbench
=================================

BOOTH_MAC_CTRL -- requirements
Module: booth_mac_ctrl

Interface
REQ-001 Parameter nb, default 8, operand width; SHALL be even and >= 4, and SHALL match the attached Booth multiplier.
REQ-002 Parameter ACC_W, default 2*nb+8, accumulator width; SHALL be >= 2*nb+1.
REQ-003 clk  in  1  rising-edge clock, single clock domain.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_valid  in  1  operand pair present.
REQ-006 in_ready  out  1  block can accept an operand pair.
REQ-007 in_a  in  nb  multiplicand, signed.
REQ-008 in_b  in  nb  multiplier, signed.
REQ-009 in_last  in  1  pair is the final term of the current dot product.
REQ-010 mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-011 mul_a  out  nb  registered multiplicand driven to the multiplier A port.
REQ-012 mul_b  out  nb  registered multiplier driven to the multiplier B port.
REQ-013 mul_product  in  2*nb  signed product from the multiplier.
REQ-014 mul_ready  in  1  multiplier done flag; level signal, may be stale-high before a start takes effect.
REQ-015 out_valid  out  1  accumulated result available.
REQ-016 out_ready  in  1  downstream accepts the result.
REQ-017 out_acc  out  ACC_W  signed dot-product sum.
REQ-018 out_count  out  16  number of terms in the result; saturates at 16'hFFFF.
REQ-019 out_ovf  out  1  sticky signed overflow of the accumulator during this frame.

Function
REQ-020 FSM states SHALL be IDLE, START, WAIT and OUT.
REQ-021 IDLE: in_ready=1; on in_valid&&in_ready, latch in_a/in_b/in_last into mul_a/mul_b/last_q and go to START.
REQ-022 START: mul_start=1 for exactly one cycle, in_ready=0; next state is WAIT unconditionally.
REQ-023 mul_ready SHALL be ignored in START, because a stale high from the previous operation must not be captured.
REQ-024 WAIT: in_ready=0, mul_start=0; when mul_ready=1, perform acc <= acc + sign_extend(mul_product) and increment the term count (saturating).
REQ-025 On that accumulation, the next state SHALL be OUT if last_q=1, else IDLE.
REQ-026 Overflow: if the operands share a sign and the sum sign differs, out_ovf SHALL set; the sum SHALL wrap modulo 2^ACC_W.
REQ-027 OUT: out_valid=1, in_ready=0; out_acc/out_count/out_ovf SHALL be held stable until out_valid&&out_ready.
REQ-028 On the OUT handshake, clear acc, count and ovf, and go to IDLE; out_valid SHALL deassert the next cycle.
REQ-029 Latency: from the accept edge to the next in_ready=1 SHALL be nb/2+2 cycles (6 for nb=8).
REQ-030 Latency: out_valid SHALL rise on the edge that accumulates a last term.
REQ-031 mul_a/mul_b SHALL be stable from START until the next accept.
REQ-032 in_valid while in_ready=0 SHALL be ignored, with no side effects.
REQ-033 out_ready while out_valid=0 SHALL have no effect.
REQ-034 A single-term frame (in_last=1 on the first pair) SHALL be legal and give out_count=1.

Reset
REQ-035 rst_n=0 SHALL immediately force the state to IDLE, with acc=0, count=0, ovf=0, last_q=0, mul_a=0, mul_b=0, mul_start=0, out_valid=0.
REQ-036 While rst_n=0, in_ready SHALL be 0; it SHALL be 1 from the first clock edge after deassertion.
REQ-037 Reset in any state SHALL abandon the in-flight operation and partial sum; a later mul_ready SHALL NOT be accumulated until a new START.

Verification
REQ-038 nb=8: pair (3,-5) with last=1 -> out_acc=-15, out_count=1, out_ovf=0; in_ready returns high 6 cycles after accept.
REQ-039 Pairs (-128,-128), (127,127), (-128,127,last) -> out_acc=16257, out_count=3, out_ovf=0.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> outputs stable and in_ready=0 throughout; accepted on cycle 6; next frame starts from acc=0.
REQ-041 ACC_W=17: four pairs (-128,-128), last on the fourth -> out_ovf=1, out_acc=-65536, out_count=4.
REQ-042 Assert rst_n=0 mid-WAIT of the second term, hold mul_ready stale-high after release, then send (2,3,last) -> out_acc=6, out_count=1.

Source files
------------

// File: rtl/booth_mac_ctrl.sv
// Booth MAC controller: issues operand pairs to an external Booth multiplier and
// accumulates the signed products into a dot-product frame with handshaked output.
module booth_mac_ctrl #(
  parameter int nb    = 8,
  parameter int ACC_W = 2*nb+8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [nb-1:0]    in_a,
  input  logic signed [nb-1:0]    in_b,
  input  logic                    in_last,
  output logic                    mul_start,
  output logic signed [nb-1:0]    mul_a,
  output logic signed [nb-1:0]    mul_b,
  input  logic signed [2*nb-1:0]  mul_product,
  input  logic                    mul_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [15:0]             out_count,
  output logic                    out_ovf
);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t                   state, state_nxt;
  logic                     alive;
  logic                     last_q;
  logic signed [ACC_W-1:0]  acc;
  logic [15:0]              count;
  logic                     ovf;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic                     accept, accum, out_fire;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*nb-1:0] p);
    return ACC_W'(p);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  assign prod_ext = sext_prod(mul_product);
  assign sum      = acc + prod_ext;

  // mul_ready is deliberately not looked at in START: it may still be high from the previous product
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    accum     = 1'b0;
    out_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = alive;
        if (in_valid && alive) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mul_ready) begin
          accum     = 1'b1;
          state_nxt = last_q ? OUT : IDLE;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // alive keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a  <= '0;
      mul_b  <= '0;
      last_q <= 1'b0;
      acc    <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        mul_a  <= in_a;
        mul_b  <= in_b;
        last_q <= in_last;
      end
      if (accum) begin
        acc   <= sum;
        count <= sat_inc(count);
        if (add_ovf(acc, prod_ext, sum))
          ovf <= 1'b1;
      end
      if (out_fire) begin
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end
    end
  end

  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Directed bench for booth_mac_ctrl: a 24-bit and a 17-bit accumulator instance
// share stimulus and a behavioural radix-4 Booth multiplier with nb/2-cycle latency.
module tb_booth_mac_ctrl;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, out_ready;
  logic signed [NB-1:0] in_a, in_b;

  logic                  in_ready0, mul_start0, out_valid0, out_ovf0;
  logic signed [NB-1:0]  mul_a0, mul_b0;
  logic signed [23:0]    out_acc0;
  logic [15:0]           out_count0;

  logic                  in_ready1, mul_start1, out_valid1, out_ovf1;
  logic signed [NB-1:0]  mul_a1, mul_b1;
  logic signed [16:0]    out_acc1;
  logic [15:0]           out_count1;

  logic signed [2*NB-1:0] m_prod = '0;
  logic                   m_rdy  = 1'b0;
  int                     m_cnt  = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  booth_mac_ctrl #(.nb(NB)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(mul_start0),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_product(m_prod), .mul_ready(m_rdy),
    .out_valid(out_valid0), .out_ready(out_ready), .out_acc(out_acc0),
    .out_count(out_count0), .out_ovf(out_ovf0)
  );

  booth_mac_ctrl #(.nb(NB), .ACC_W(17)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(mul_start1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_product(m_prod), .mul_ready(m_rdy),
    .out_valid(out_valid1), .out_ready(out_ready), .out_acc(out_acc1),
    .out_count(out_count1), .out_ovf(out_ovf1)
  );

  // Multiplier model: ready drops on start, rises nb/2 edges later, then stays high
  always @(posedge clk) begin
    if (mul_start0) begin
      m_rdy <= 1'b0;
      m_cnt <= NB/2;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_rdy  <= 1'b1;
        m_prod <= mul_a0 * mul_b0;
      end
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input logic last);
    int n = 0;
    while (!in_ready0 && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", in_ready0, 1);
    in_valid = 1'b1;
    in_a     = NB'(a);
    in_b     = NB'(b);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid0 && cycles < 50) begin
      tick();
      cycles++;
    end
    chk("out_valid_timeout", out_valid0, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_out_valid_low", out_valid0, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #3;
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_mul_start", mul_start0, 0);
    tick(); tick();
    chk("rst_held_in_ready", in_ready0, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_before_edge_in_ready", in_ready0, 0);
    tick();
    chk("rel_in_ready", in_ready0, 1);
    chk("rel_acc", out_acc0, 0);

    // Single-term frame (3,-5) and accept-to-ready latency
    send(3, -5, 1'b1);
    chk("start_pulse", mul_start0, 1);
    chk("start_in_ready", in_ready0, 0);
    chk("mul_a_latched", mul_a0, 3);
    chk("mul_b_latched", mul_b0, -5);
    tick();
    chk("start_one_cycle", mul_start0, 0);
    cyc = 1;
    while (!out_valid0 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("single_latency", cyc, 6);
    chk("single_acc", out_acc0, -15);
    chk("single_count", out_count0, 1);
    chk("single_ovf", out_ovf0, 0);
    chk("out_in_ready", in_ready0, 0);
    drain();
    chk("clear_acc", out_acc0, 0);
    chk("clear_count", out_count0, 0);
    chk("after_out_in_ready", in_ready0, 1);

    // out_ready without out_valid is inert
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stray_out_ready_in_ready", in_ready0, 1);
    chk("stray_out_ready_valid", out_valid0, 0);

    // Three-term frame, with an in_valid pulse while busy that must be ignored
    send(-128, -128, 1'b0);
    tick();
    in_valid = 1'b1; in_a = 8'sd7; in_b = 8'sd9;
    tick();
    in_valid = 1'b0;
    chk("busy_mul_a", mul_a0, -128);
    chk("busy_mul_b", mul_b0, -128);
    cyc = 2;
    while (!in_ready0 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("term_latency", cyc, 6);
    chk("term1_count", out_count0, 1);
    chk("term1_acc", out_acc0, 16384);
    send(127, 127, 1'b0);
    send(-128, 127, 1'b1);
    wait_out(cyc);
    chk("three_acc", out_acc0, 16257);
    chk("three_count", out_count0, 3);
    chk("three_ovf", out_ovf0, 0);

    // Backpressure: five cycles held, accepted on the sixth
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", out_valid0, 1);
      chk("bp_in_ready", in_ready0, 0);
      chk("bp_acc", out_acc0, 16257);
      chk("bp_count", out_count0, 3);
    end
    drain();
    send(2, 2, 1'b1);
    wait_out(cyc);
    chk("next_frame_acc", out_acc0, 4);
    chk("next_frame_count", out_count0, 1);
    drain();

    // Overflow on the 17-bit instance; the 24-bit instance holds the true sum
    for (int i = 0; i < 4; i++)
      send(-128, -128, (i == 3));
    wait_out(cyc);
    chk("ovf17_valid", out_valid1, 1);
    chk("ovf17_flag", out_ovf1, 1);
    chk("ovf17_acc", out_acc1, -65536);
    chk("ovf17_count", out_count1, 4);
    chk("ovf24_acc", out_acc0, 65536);
    chk("ovf24_flag", out_ovf0, 0);
    drain();
    chk("ovf17_cleared", out_ovf1, 0);
    chk("ovf17_in_ready", in_ready1, 1);

    // Reset mid-WAIT of the second term, stale mul_ready after release
    send(5, 5, 1'b0);
    send(1, 1, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready0, 0);
    chk("midrst_count", out_count0, 0);
    chk("midrst_mul_a", mul_a0, 0);
    tick(); tick(); tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("stale_rdy_present", m_rdy, 1);
    chk("stale_count", out_count0, 0);
    chk("stale_in_ready", in_ready0, 1);
    send(2, 3, 1'b1);
    wait_out(cyc);
    chk("postrst_acc", out_acc0, 6);
    chk("postrst_count", out_count0, 1);
    chk("postrst_mul_b1", mul_b1, 3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
